// File: rtl/perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : perf_event_monitor
// Description : Performance-counter bank for the pipelined CPU. One cycle
//               counter plus NUM_EVT event counters, all saturating, armed by
//               start and frozen on CPU halt or on a cycle-count watchdog.
//               A registered read port returns any counter one cycle later.
// Ports       : clk, rst          clock / synchronous active-high reset
//               clear_i           soft clear of counters, flags and FSM
//               start_i           arm counting (IDLE -> RUN)
//               evt_i             event strobes, bit i -> counter i+1
//               hlt_i             CPU halt, freezes counters
//               rd_en_i, rd_sel_i read request / counter select (0 = cycles)
//               rd_data_o, rd_valid_o, rd_err_o  registered read response
//               ovf_o             sticky saturation flags per counter
//               state_o, done_o   FSM state and HALTED/TIMEOUT indication
// Revision    : 1.0 - initial release
// ============================================================================
module perf_event_monitor #(
  parameter int          NUM_EVT    = 6,
  parameter int          CNT_W      = 32,
  parameter int unsigned WDOG_LIMIT = 100000,
  localparam int         SEL_W      = $clog2(NUM_EVT + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               start_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               hlt_i,
  input  logic               rd_en_i,
  input  logic [SEL_W-1:0]   rd_sel_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic               rd_err_o,
  output logic [NUM_EVT:0]   ovf_o,
  output logic [1:0]         state_o,
  output logic               done_o
);

  localparam int NCNT = NUM_EVT + 1;
  // The watchdog compare is done at a width that holds both the counter and
  // the limit, so a limit larger than the counter range can never alias.
  localparam int XW   = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [1:0] S_IDLE    = 2'b00;
  localparam logic [1:0] S_RUN     = 2'b01;
  localparam logic [1:0] S_HALTED  = 2'b10;
  localparam logic [1:0] S_TIMEOUT = 2'b11;

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_EVT);
  localparam logic [XW-1:0]    WDOG_X  = XW'(WDOG_LIMIT);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q [NCNT];
  logic [CNT_W-1:0] cnt_d [NCNT];
  logic [NUM_EVT:0] ovf_q, ovf_d;
  logic [NUM_EVT:0] cnt_inc;
  logic             wdog_hit;
  logic [CNT_W-1:0] rd_data_q, rd_sel_data;
  logic             rd_valid_q, rd_err_q, rd_err_d;

  // Counter update: bit 0 is the cycle counter, which always counts in RUN.
  always_comb begin
    cnt_inc = {evt_i, 1'b1} & {NCNT{state_q == S_RUN}};
    ovf_d   = ovf_q;
    for (int i = 0; i < NCNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cnt_inc[i]) begin
        if (&cnt_q[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Watchdog looks at the post-increment (saturated) cycle count.
  assign wdog_hit = (WDOG_LIMIT != 0) && (XW'(cnt_d[0]) == WDOG_X);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (hlt_i)         state_d = S_HALTED;
        else if (wdog_hit) state_d = S_TIMEOUT;
      end
      default: state_d = state_q;
    endcase
  end

  // Read mux; an out-of-range select matches no counter and yields zero.
  always_comb begin
    rd_err_d    = rd_sel_i > MAX_SEL;
    rd_sel_data = '0;
    for (int i = 0; i < NCNT; i++) begin
      if (rd_sel_i == SEL_W'(i)) rd_sel_data = cnt_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ovf_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
      for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
    end else begin
      // The read port samples pre-edge counter values, so a read issued
      // together with clear still returns the pre-clear count.
      rd_valid_q <= rd_en_i;
      rd_err_q   <= rd_en_i & rd_err_d;
      if (rd_en_i)      rd_data_q <= rd_sel_data;
      else if (clear_i) rd_data_q <= '0;

      if (clear_i) begin
        state_q <= S_IDLE;
        ovf_q   <= '0;
        for (int i = 0; i < NCNT; i++) cnt_q[i] <= '0;
      end else begin
        state_q <= state_d;
        ovf_q   <= ovf_d;
        for (int i = 0; i < NCNT; i++) cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign rd_err_o   = rd_err_q;
  assign ovf_o      = ovf_q;
  assign state_o    = state_q;
  assign done_o     = state_q[1];

endmodule
`default_nettype wire

// File: tb/tb_perf_event_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_perf_event_monitor
// Description : Bench for perf_event_monitor. Two instances share one input
//               bus: A (8-bit counters, watchdog off) and B (32-bit counters,
//               watchdog at 50). A cycle-level reference model predicts every
//               output of both instances each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_perf_event_monitor;

  localparam int NE = 6;

  logic       clk = 1'b0;
  logic       rst, clear, start, hlt, rd_en;
  logic [5:0] evt;
  logic [2:0] rd_sel;

  logic [7:0]  rd_data_a;
  logic [31:0] rd_data_b;
  logic        rd_valid_a, rd_valid_b, rd_err_a, rd_err_b, done_a, done_b;
  logic [6:0]  ovf_a, ovf_b;
  logic [1:0]  state_a, state_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(8), .WDOG_LIMIT(0)) u_a (
    .clk(clk), .rst(rst), .clear_i(clear), .start_i(start), .evt_i(evt),
    .hlt_i(hlt), .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data_a),
    .rd_valid_o(rd_valid_a), .rd_err_o(rd_err_a), .ovf_o(ovf_a),
    .state_o(state_a), .done_o(done_a));

  perf_event_monitor #(.NUM_EVT(NE), .CNT_W(32), .WDOG_LIMIT(50)) u_b (
    .clk(clk), .rst(rst), .clear_i(clear), .start_i(start), .evt_i(evt),
    .hlt_i(hlt), .rd_en_i(rd_en), .rd_sel_i(rd_sel), .rd_data_o(rd_data_b),
    .rd_valid_o(rd_valid_b), .rd_err_o(rd_err_b), .ovf_o(ovf_b),
    .state_o(state_b), .done_o(done_b));

  // ---------------- reference model ----------------
  // States: 0 idle, 1 counting, 2 halted, 3 timed out.
  longint maxv [2] = '{64'd255, 64'hFFFF_FFFF};
  longint wdog [2] = '{64'd0, 64'd50};
  longint mc   [2][7];
  bit     mo   [2][7];
  int     ms   [2];
  bit     mv   [2];
  bit     me   [2];
  longint md   [2];

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        for (int j = 0; j < 7; j++) begin mc[m][j] = 0; mo[m][j] = 0; end
        ms[m] = 0; mv[m] = 0; me[m] = 0; md[m] = 0;
      end else begin
        if (rd_en) begin
          mv[m] = 1;
          me[m] = (rd_sel > 3'd6);
          md[m] = me[m] ? 0 : mc[m][rd_sel];
        end else begin
          mv[m] = 0;
          me[m] = 0;
          if (clear) md[m] = 0;
        end
        if (clear) begin
          for (int j = 0; j < 7; j++) begin mc[m][j] = 0; mo[m][j] = 0; end
          ms[m] = 0;
        end else if (ms[m] == 0) begin
          if (start) ms[m] = 1;
        end else if (ms[m] == 1) begin
          for (int j = 0; j < 7; j++) begin
            if (j == 0 || evt[j-1]) begin
              if (mc[m][j] == maxv[m]) mo[m][j] = 1;
              else                     mc[m][j] = mc[m][j] + 1;
            end
          end
          if (hlt)                                     ms[m] = 2;
          else if (wdog[m] != 0 && mc[m][0] == wdog[m]) ms[m] = 3;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_inst(input int m, input string nm, input logic [1:0] st,
                            input logic dn, input logic [6:0] ov, input logic vl,
                            input logic er, input logic [63:0] dt);
    logic [6:0] eov;
    for (int j = 0; j < 7; j++) eov[j] = mo[m][j];
    chk({nm, "_state"}, 64'(st), 64'(ms[m]));
    chk({nm, "_done"}, 64'(dn), 64'(ms[m] >= 2));
    chk({nm, "_ovf"}, 64'(ov), 64'(eov));
    chk({nm, "_rd_valid"}, 64'(vl), 64'(mv[m]));
    chk({nm, "_rd_err"}, 64'(er), 64'(me[m]));
    chk({nm, "_rd_data"}, dt, 64'(md[m]));
  endtask

  // One clock: model advances on the edge, outputs compared half a cycle later.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_inst(0, "a", state_a, done_a, ovf_a, rd_valid_a, rd_err_a, 64'(rd_data_a));
    check_inst(1, "b", state_b, done_b, ovf_b, rd_valid_b, rd_err_b, 64'(rd_data_b));
  endtask

  task automatic idle_inputs();
    rst = 0; clear = 0; start = 0; hlt = 0; rd_en = 0; rd_sel = 0; evt = 0;
  endtask

  task automatic do_clear_start();
    idle_inputs(); clear = 1; cycle();
    idle_inputs(); start = 1; cycle();
    idle_inputs();
  endtask

  task automatic read(input logic [2:0] sel);
    rd_en = 1; rd_sel = sel; cycle(); rd_en = 0;
  endtask

  initial begin
    idle_inputs();
    // T1: reset with events asserted, then idle without start.
    rst = 1; evt = 6'h3F;
    cycle(); cycle();
    rst = 0;
    for (int k = 0; k < 10; k++) cycle();
    chk("t1_state_a", 64'(state_a), 64'd0);
    chk("t1_valid_b", 64'(rd_valid_b), 64'd0);
    evt = 0;
    for (int s = 0; s < 8; s++) begin
      read(3'(s));
      chk("t1_read_b", 64'(rd_data_b), 64'd0);
    end
    chk("t1_ovf_b", 64'(ovf_b), 64'd0);

    // T2: 20 counting cycles, event every other cycle, halt on the last.
    idle_inputs(); start = 1; cycle(); start = 0;
    for (int k = 0; k < 20; k++) begin
      evt = (k % 2 == 0) ? 6'h01 : 6'h00;
      hlt = (k == 19);
      cycle();
    end
    idle_inputs();
    chk("t2_state_b", 64'(state_b), 64'd2);
    chk("t2_done_a", 64'(done_a), 64'd1);
    read(0); chk("t2_cyc_b", 64'(rd_data_b), 64'd20);
    read(1); chk("t2_evt0_a", 64'(rd_data_a), 64'd10);
    evt = 6'h3F; start = 1;
    for (int k = 0; k < 5; k++) cycle();
    idle_inputs();
    read(0); chk("t2_frozen_cyc", 64'(rd_data_b), 64'd20);
    read(1); chk("t2_frozen_evt", 64'(rd_data_b), 64'd10);

    // T3: saturation of the 8-bit instance.
    do_clear_start();
    evt = 6'h02;
    for (int k = 0; k < 300; k++) cycle();
    evt = 0;
    read(2); chk("t3_evt1_a", 64'(rd_data_a), 64'hFF);
    read(0); chk("t3_cyc_a", 64'(rd_data_a), 64'hFF);
    chk("t3_ovf_a", 64'(ovf_a & 7'h05), 64'h05);

    // T4: watchdog on instance B after exactly 50 counting cycles.
    do_clear_start();
    for (int k = 1; k <= 50; k++) begin
      cycle();
      if (k == 49) chk("t4_state_49", 64'(state_b), 64'd1);
    end
    chk("t4_timeout", 64'(state_b), 64'd3);
    read(0); chk("t4_cyc_b", 64'(rd_data_b), 64'd50);
    do_clear_start();
    for (int k = 1; k <= 50; k++) begin
      hlt = (k == 50);
      cycle();
    end
    hlt = 0;
    chk("t4_halt_wins", 64'(state_b), 64'd2);

    // T5: read latency, same-cycle event exclusion, out-of-range select.
    do_clear_start();
    evt = 6'h01;
    for (int k = 0; k < 3; k++) cycle();
    rd_en = 1; rd_sel = 1; cycle();
    chk("t5_valid", 64'(rd_valid_b), 64'd1);
    chk("t5_excl", 64'(rd_data_b), 64'd3);
    evt = 0; rd_sel = 7; cycle();
    chk("t5_err", 64'(rd_err_b), 64'd1);
    chk("t5_err_data", 64'(rd_data_b), 64'd0);
    rd_en = 0; cycle();
    chk("t5_valid_low", 64'(rd_valid_b), 64'd0);
    read(1); chk("t5_after", 64'(rd_data_b), 64'd4);

    // T6: clear mid-run, read coincident with clear, resume from zero.
    do_clear_start();
    evt = 6'h01;
    for (int k = 0; k < 5; k++) cycle();
    evt = 0; clear = 1; rd_en = 1; rd_sel = 1; cycle();
    chk("t6_read_preclear", 64'(rd_data_b), 64'd5);
    idle_inputs(); cycle();
    chk("t6_state", 64'(state_b), 64'd0);
    chk("t6_ovf", 64'(ovf_a), 64'd0);
    read(1); chk("t6_zero", 64'(rd_data_b), 64'd0);
    start = 1; cycle(); start = 0;
    evt = 6'h01;
    for (int k = 0; k < 3; k++) cycle();
    evt = 0;
    read(1); chk("t6_resume", 64'(rd_data_b), 64'd3);
    rd_en = 1; rd_sel = 0; rst = 1; cycle();
    chk("t6_rst_read", 64'(rd_valid_b), 64'd0);
    idle_inputs(); cycle();

    // Randomized phase against the model.
    for (int r = 0; r < 16; r++) begin
      do_clear_start();
      for (int n = 0; n < int'($urandom_range(40, 220)); n++) begin
        evt    = 6'($urandom);
        hlt    = ($urandom_range(0, 60) == 0);
        start  = ($urandom_range(0, 3) == 0);
        rd_en  = 1'($urandom_range(0, 1));
        rd_sel = 3'($urandom_range(0, 7));
        clear  = ($urandom_range(0, 80) == 0);
        rst    = ($urandom_range(0, 200) == 0);
        cycle();
      end
      idle_inputs();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
